// File: rtl/arc4_pkg.sv
// Shared constants and types for the ARC4 keystream/decrypt engine.
// The state encodings are fixed constants so the netlist encoding stays stable.
package arc4_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t LEN_ADDR = 8'd0;

    typedef logic [3:0] prga_state_t;

    localparam prga_state_t ST_IDLE   = 4'd0;
    localparam prga_state_t ST_RD_LEN = 4'd1;
    localparam prga_state_t ST_WR_LEN = 4'd2;
    localparam prga_state_t ST_RD_SI  = 4'd3;
    localparam prga_state_t ST_RD_SJ  = 4'd4;
    localparam prga_state_t ST_WR_SI  = 4'd5;
    localparam prga_state_t ST_WR_SJ  = 4'd6;
    localparam prga_state_t ST_RD_PAD = 4'd7;
    localparam prga_state_t ST_WR_PT  = 4'd8;

endpackage

// File: rtl/prga_dp.sv
// PRGA datapath: index registers, the swapped S values and the address adders.
// All arithmetic is 8-bit and wraps modulo 256 by construction.
module prga_dp
    import arc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  ld_n_i,
    input  byte_t len_i,
    input  logic  init_ik_i,
    input  logic  inc_ik_i,
    input  logic  ld_si_i,
    input  logic  ld_sj_i,
    input  byte_t s_rddata_i,
    output byte_t i_o,
    output byte_t j_o,
    output byte_t j_next_o,
    output byte_t k_o,
    output byte_t s_i_o,
    output byte_t pad_addr_o,
    output logic  last_o
);

    byte_t i_q, i_d;
    byte_t j_q, j_d;
    byte_t k_q, k_d;
    byte_t n_q, n_d;
    byte_t s_i_q, s_i_d;
    byte_t s_j_q, s_j_d;

    assign j_next_o   = j_q + s_rddata_i;
    assign pad_addr_o = s_i_q + s_j_q;
    assign last_o     = (k_q == n_q);

    assign i_o   = i_q;
    assign j_o   = j_q;
    assign k_o   = k_q;
    assign s_i_o = s_i_q;

    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        n_d   = n_q;
        s_i_d = s_i_q;
        s_j_d = s_j_q;
        if (clr_i) begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            n_d   = '0;
            s_i_d = '0;
            s_j_d = '0;
        end
        if (ld_n_i) begin
            n_d = len_i;
        end
        if (init_ik_i) begin
            i_d = 8'd1;
            k_d = 8'd1;
        end
        if (inc_ik_i) begin
            i_d = i_q + 8'd1;
            k_d = k_q + 8'd1;
        end
        // j advances in the same cycle S[i] is captured, so the S[j] read sees the new j
        if (ld_si_i) begin
            s_i_d = s_rddata_i;
            j_d   = j_next_o;
        end
        if (ld_sj_i) begin
            s_j_d = s_rddata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            n_q   <= '0;
            s_i_q <= '0;
            s_j_q <= '0;
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            n_q   <= n_d;
            s_i_q <= s_i_d;
            s_j_q <= s_j_d;
        end
    end

endmodule

// File: rtl/prga.sv
// ARC4 PRGA/decrypt controller: walks ct[1..N] against a KSA-permuted S RAM
// and writes pt[0..N]; six cycles per byte over synchronous-read RAMs.
module prga
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [BYTE_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [BYTE_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    prga_state_t state_q, state_d;

    logic  clr, ld_n, init_ik, inc_ik, ld_si, ld_sj, last;
    byte_t i_v, j_v, j_next, k_v, s_i_v, pad_addr;

    prga_dp u_dp (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .ld_n_i     (ld_n),
        .len_i      (ct_rddata),
        .init_ik_i  (init_ik),
        .inc_ik_i   (inc_ik),
        .ld_si_i    (ld_si),
        .ld_sj_i    (ld_sj),
        .s_rddata_i (s_rddata),
        .i_o        (i_v),
        .j_o        (j_v),
        .j_next_o   (j_next),
        .k_o        (k_v),
        .s_i_o      (s_i_v),
        .pad_addr_o (pad_addr),
        .last_o     (last)
    );

    always_comb begin
        state_d   = state_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        clr       = 1'b0;
        ld_n      = 1'b0;
        init_ik   = 1'b0;
        inc_ik    = 1'b0;
        ld_si     = 1'b0;
        ld_sj     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    clr     = 1'b1;
                    state_d = ST_RD_LEN;
                end
            end
            ST_RD_LEN: begin
                ct_addr = LEN_ADDR;
                state_d = ST_WR_LEN;
            end
            ST_WR_LEN: begin
                ld_n      = 1'b1;
                pt_addr   = LEN_ADDR;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                if (ct_rddata == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    init_ik = 1'b1;
                    state_d = ST_RD_SI;
                end
            end
            ST_RD_SI: begin
                s_addr  = i_v;
                state_d = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                ld_si   = 1'b1;
                s_addr  = j_next;
                state_d = ST_WR_SI;
            end
            // S[j] arrives now and goes straight back into S[i]; i==j rewrites the same value
            ST_WR_SI: begin
                ld_sj    = 1'b1;
                s_addr   = i_v;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                s_addr   = j_v;
                s_wrdata = s_i_v;
                s_wren   = 1'b1;
                state_d  = ST_RD_PAD;
            end
            ST_RD_PAD: begin
                s_addr  = pad_addr;
                ct_addr = k_v;
                state_d = ST_WR_PT;
            end
            ST_WR_PT: begin
                pt_addr   = k_v;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (last) begin
                    state_d = ST_IDLE;
                end else begin
                    inc_ik  = 1'b1;
                    state_d = ST_RD_SI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_prga.sv
// Scoreboard bench for prga: a software ARC4 PRGA model predicts every pt write,
// per-message busy time and S-write count; a negedge monitor checks the DUT against it.
module tb_prga;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic       load_s;
    logic       pt_clr;
    logic       mon_en;

    int model_s [256];
    int exp_pt_q  [$];
    int exp_lat_q [$];
    int exp_swr_q [$];

    int checks   = 0;
    int failures = 0;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read RAM models with one-cycle bulk load/clear
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (load_s) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        if (pt_clr) begin
            for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hFF;
        end else if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // reference ARC4 PRGA on the model S; nswap bytes permute S, the first npt are written
    task automatic model_msg(input int n, input int nswap, input int npt, input int lat);
        int i = 0;
        int j = 0;
        int t;
        exp_pt_q.push_back(n);
        for (int k = 1; k <= nswap; k++) begin
            i = (i + 1) % 256;
            j = (j + model_s[i]) % 256;
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
            if (k <= npt)
                exp_pt_q.push_back(k * 256 + (int'(ct_mem[k]) ^ model_s[(model_s[i] + model_s[j]) % 256]));
        end
        exp_lat_q.push_back(lat);
        exp_swr_q.push_back(2 * nswap);
    endtask

    task automatic pulse_load(input logic do_s, input logic do_pt);
        load_s = do_s;
        pt_clr = do_pt;
        @(posedge clk);
        #1;
        load_s = 1'b0;
        pt_clr = 1'b0;
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = 8'(x);
            model_s[x] = x;
        end
        pulse_load(1'b1, 1'b1);
    endtask

    task automatic load_ksa();
        int key [16];
        int j = 0;
        int t;
        for (int x = 0; x < 16; x++) key[x] = int'($urandom_range(0, 255));
        for (int x = 0; x < 256; x++) model_s[x] = x;
        for (int x = 0; x < 256; x++) begin
            j = (j + model_s[x] + key[x % 16]) % 256;
            t = model_s[x];
            model_s[x] = model_s[j];
            model_s[j] = t;
        end
        for (int x = 0; x < 256; x++) s_init[x] = 8'(model_s[x]);
        pulse_load(1'b1, 1'b1);
    endtask

    task automatic set_ct(input int n);
        ct_mem[0] = 8'(n);
        for (int x = 1; x <= n; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    endtask

    task automatic start(input logic hold);
        int t = 0;
        while (!rdy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("start_rdy", int'(rdy), 1);
        en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!rdy && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", int'(rdy), 1);
    endtask

    task automatic check_s(input string name);
        int bad = 0;
        for (int x = 0; x < 256; x++)
            if (int'(s_mem[x]) != model_s[x]) bad++;
        check(name, bad, 0);
    endtask

    // monitor: pops expected pt writes, busy length and S-write count per message
    initial begin
        int lowcnt = 0;
        int swcnt  = 0;
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (s_wren || pt_wren) check("wren_excl", int'(s_wren & pt_wren), 0);
                if (pt_wren) begin
                    if (exp_pt_q.size() == 0) begin
                        check("pt_unexpected", int'(pt_addr), -1);
                    end else begin
                        e = exp_pt_q.pop_front();
                        check("pt_addr", int'(pt_addr), e / 256);
                        check("pt_data", int'(pt_wrdata), e % 256);
                    end
                end
                if (!rdy) begin
                    lowcnt++;
                    if (s_wren) swcnt++;
                end else if (lowcnt > 0) begin
                    if (exp_lat_q.size() == 0) begin
                        check("lat_unexpected", lowcnt, -1);
                    end else begin
                        check("rdy_low_cycles", lowcnt, exp_lat_q.pop_front());
                        check("s_write_count", swcnt, exp_swr_q.pop_front());
                    end
                    $display("msg done busy=%0d s_writes=%0d", lowcnt, swcnt);
                    lowcnt = 0;
                    swcnt  = 0;
                end
            end
        end
    end

    initial begin
        int n;
        rst    = 1'b1;
        en     = 1'b0;
        load_s = 1'b0;
        pt_clr = 1'b0;
        mon_en = 1'b0;
        for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", int'(rdy), 1);
        check("rst_s_wren", int'(s_wren), 0);
        check("rst_pt_wren", int'(pt_wren), 0);
        check("rst_addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
        check("rst_wrdata", int'(s_wrdata) + int'(pt_wrdata), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // identity S, one zero byte
        load_identity();
        set_ct(1);
        ct_mem[1] = 8'h00;
        model_msg(1, 1, 1, 8);
        start(1'b0);
        wait_done(100);
        check("id1_pt0", int'(pt_mem[0]), 1);
        check("id1_pt1", int'(pt_mem[1]), 2);
        check_s("id1_s");
        $display("msg N=1 identity pt1=%0d", pt_mem[1]);

        // identity S, two zero bytes
        load_identity();
        set_ct(2);
        ct_mem[1] = 8'h00;
        ct_mem[2] = 8'h00;
        model_msg(2, 2, 2, 14);
        start(1'b0);
        wait_done(100);
        check("id2_pt1", int'(pt_mem[1]), 2);
        check("id2_pt2", int'(pt_mem[2]), 5);
        check("id2_s2", int'(s_mem[2]), 3);
        check("id2_s3", int'(s_mem[3]), 2);
        check_s("id2_s");
        $display("msg N=2 identity pt2=%0d", pt_mem[2]);

        // empty message
        load_identity();
        set_ct(0);
        model_msg(0, 0, 0, 2);
        start(1'b0);
        wait_done(100);
        check("n0_pt0", int'(pt_mem[0]), 0);
        check_s("n0_s");
        $display("msg N=0 pt0=%0d", pt_mem[0]);

        // abort in WR_SJ of byte 3, then restart with N=1
        load_identity();
        set_ct(5);
        model_msg(5, 3, 2, 18);
        start(1'b0);
        repeat (17) @(posedge clk);
        #1;
        check("abort_in_wr_sj", int'(s_wren), 1);
        en  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        check("abort_rdy", int'(rdy), 1);
        check("abort_wren", int'(s_wren) + int'(pt_wren), 0);
        check_s("abort_s");
        set_ct(1);
        model_msg(1, 1, 1, 8);
        start(1'b0);
        wait_done(100);
        check_s("restart_s");
        $display("msg abort+restart pt1=%0d", pt_mem[1]);

        // full-length message on a KSA-permuted S
        load_ksa();
        set_ct(255);
        model_msg(255, 255, 255, 1532);
        start(1'b0);
        wait_done(2000);
        check_s("n255_s");
        $display("msg N=255 done");

        // en held across two back-to-back messages
        n = int'($urandom_range(3, 9));
        set_ct(n);
        model_msg(n, n, n, 2 + 6 * n);
        model_msg(n, n, n, 2 + 6 * n);
        start(1'b1);
        wait_done(200);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        check("b2b_restart", int'(rdy), 0);
        wait_done(200);
        check_s("b2b_s");
        $display("msg back-to-back N=%0d", n);

        // random lengths on the evolving S
        for (int m = 0; m < 4; m++) begin
            n = int'($urandom_range(0, 24));
            set_ct(n);
            model_msg(n, n, n, 2 + 6 * n);
            start(1'b0);
            wait_done(400);
            check_s("rand_s");
            $display("msg random N=%0d", n);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pt_q_empty", exp_pt_q.size(), 0);
        check("lat_q_empty", exp_lat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 en  in  1  start request, sampled only while rdy=1.
REQ-005 rdy  out  1  high only in IDLE; en&rdy in a cycle starts one message.
REQ-006 s_addr/s_rddata/s_wrdata/s_wren  out/in/out/out  8/8/8/1  S-box RAM port, KSA-permuted S.
REQ-007 ct_addr/ct_rddata  out/in  8/8  ciphertext RAM; ct[0]=length N, ct[1..N]=bytes.
REQ-008 pt_addr/pt_wrdata/pt_wren  out/out/out  8/8/1  plaintext RAM; same layout as ct.
REQ-009 All RAMs SHALL be synchronous-read: rddata valid the cycle after addr is driven.

Function
REQ-010 Per byte k=1..N: i=i+1; j=j+S[i]; swap S[i],S[j]; pt[k]=ct[k] XOR S[(S[i]+S[j]) mod 256].
REQ-011 All index arithmetic SHALL be 8-bit modulo 256; j wraps silently.
REQ-012 i and j SHALL be cleared to 0 at every accepted start; i equals k throughout.
REQ-013 States: IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT.
REQ-014 IDLE: rdy=1, all wren=0; en -> RD_LEN; en otherwise ignored.
REQ-015 RD_LEN: ct_addr=0 -> WR_LEN.
REQ-016 WR_LEN: latch N=ct_rddata; pt_addr=0, pt_wrdata=N, pt_wren=1; N=0 -> IDLE, else i=1,k=1 -> RD_SI.
REQ-017 RD_SI: s_addr=i -> RD_SJ.
REQ-018 RD_SJ: latch s_i=s_rddata; j=j+s_rddata; s_addr=new j (combinational) -> WR_SI.
REQ-019 WR_SI: latch s_j=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1 -> WR_SJ.
REQ-020 WR_SJ: s_addr=j, s_wrdata=s_i, s_wren=1 -> RD_PAD.
REQ-021 RD_PAD: s_addr=s_i+s_j, ct_addr=k -> WR_PT.
REQ-022 WR_PT: pt_addr=k, pt_wrdata=s_rddata XOR ct_rddata, pt_wren=1; k=N -> IDLE, else i,k +1 -> RD_SI.
REQ-023 Latency: rdy SHALL be low for exactly 2+6N cycles per message.
REQ-024 i=j case SHALL produce unchanged S[i] (both writes carry same value).
REQ-025 s_wren and pt_wren SHALL never assert in the same cycle; no RAM written outside REQ-016/019/020/022.
REQ-026 en held high continuously SHALL start a new message on each return to IDLE.
REQ-027 Unused outputs per state SHALL drive 0; unreachable state encodings -> IDLE.

Reset
REQ-028 rst SHALL force IDLE, rdy=1, all addr/wrdata=0, all wren=0, i=j=k=N=s_i=s_j=0 next cycle.
REQ-029 rst mid-message SHALL abort; partially written pt and permuted S are not restored.
REQ-030 rst has priority over en in the same cycle.

Structure
REQ-031 arc4_pkg SHALL hold the prga state enum, BYTE_W=8, LEN_ADDR=0.
REQ-032 One sub-module SHALL be natural: prga_dp (i/j/k/s_i/s_j registers and address adders); FSM stays in prga.

Verification
REQ-033 Identity S (S[x]=x), N=1, ct[1]=0x00 -> pt[0]=0x01, pt[1]=0x02; rdy low 8 cycles.
REQ-034 Identity S, N=2, ct[1..2]=0x00,0x00 -> pt[1]=0x02, pt[2]=0x05; S[2]=3, S[3]=2 afterwards.
REQ-035 N=0 -> pt[0]=0x00, no S write, rdy low 2 cycles.
REQ-036 rst asserted in WR_SJ of byte 3 -> next cycle rdy=1, all wren=0; new en with N=1 restarts i=j=0.
REQ-037 N=255, random KSA-permuted S -> pt matches software ARC4 model byte-for-byte; rdy low 1532 cycles; j wraps without error.
REQ-038 en held high across two back-to-back messages -> second starts the cycle rdy returns high, both correct.
